sdram_traffic_gen: RTL
======================

SDRAM_TRAFFIC_GEN -- requirements
Module: sdram_traffic_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DW, 16, SDRAM data width.
- AW, 24, controller address width.
- BLW, 10, burst-length field width.
- BST_LEN, 10, beats per burst.
- NUM_BURSTS, 4, bursts per pass.
- BASE_ADDR, 0, first burst address.
- PATTERN, 0, data pattern: 0 = incrementing, 1 = LFSR.
- LOOP, 0, pass mode: 0 = single pass, 1 = continuous passes.
REQ-002 The block SHALL use reset rst_n (asynchronous, active-low) and clock clk.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pass request.
- init_end, in, 1, controller initialisation complete.
- wr_req, out, 1, write burst request.
- wr_addr, out, AW, write burst address.
- wr_data, out, DW, write beat data.
- wr_bst_len, out, BLW, write burst length.
- wr_ack, in, 1, write beat consumed.
- rd_req, out, 1, read burst request.
- rd_addr, out, AW, read burst address.
- rd_bst_len, out, BLW, read burst length.
- rd_ack, in, 1, read beat valid.
- rd_data, in, DW, read beat data.
- busy, out, 1, pass in progress.
- done, out, 1, one-cycle pulse at end of pass.
- pass, out, 1, last pass error-free.
- err_cnt, out, 16, saturating mismatch count.
- first_err_addr, out, AW, address of first mismatch.

Function
REQ-004 The FSM SHALL have states IDLE, WR, WR_NEXT, RD, RD_NEXT, FIN.
REQ-005 IDLE SHALL move to WR when start=1 and init_end=1; start SHALL be ignored otherwise, and in all states except IDLE.
REQ-006 Entering WR SHALL clear err_cnt, pass, first_err_addr, the beat counter and the burst counter, and SHALL load the pattern generator with seed 0 (INC) or {DW{1'b1}} (LFSR).
REQ-007 wr_req SHALL be a registered output, high in the first WR cycle and throughout WR.
REQ-008 wr_data SHALL advance to the next pattern word on every cycle with wr_ack=1 while in WR.
REQ-009 wr_req SHALL be low in the cycle after the BST_LEN-th wr_ack of a burst.
REQ-010 WR SHALL move to WR_NEXT (one-cycle gap) after the last beat; WR_NEXT SHALL go to WR if bursts remain, else to RD with the generator reloaded to the seed.
REQ-011 wr_addr and rd_addr SHALL equal BASE_ADDR + burst_idx*BST_LEN, truncated to AW bits.
REQ-012 wr_bst_len and rd_bst_len SHALL be the constant BST_LEN.
REQ-013 RD and RD_NEXT SHALL mirror WR and WR_NEXT, counting rd_ack beats.
REQ-014 Each rd_ack beat SHALL be compared, in the same cycle, with the regenerated expected word.
REQ-015 On a mismatch, err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-016 On the first mismatch of a pass, first_err_addr SHALL capture the burst address plus the beat index.
REQ-017 After the final read burst the FSM SHALL enter FIN for one cycle, pulse done, and set pass = (err_cnt==0).
REQ-018 FIN SHALL then go to IDLE, or to WR with seed+1 (INC) or the continued LFSR state (LFSR) when LOOP=1.
REQ-019 The INC pattern SHALL be word = seed + global beat index, modulo 2^DW.
REQ-020 The LFSR pattern SHALL be a DW-bit Galois LFSR stepped once per beat, with a maximal-length taps constant per DW.
REQ-021 wr_ack in any state other than WR SHALL be ignored.
REQ-022 rd_ack in any state other than RD SHALL be ignored and SHALL not be counted as an error.
REQ-023 If init_end falls while busy, wr_req and rd_req SHALL drop in the next cycle, the FSM SHALL return to IDLE, and done SHALL not pulse.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 Reset SHALL put the FSM in IDLE.
REQ-026 Reset SHALL drive wr_req, rd_req, busy, done and pass to 0.
REQ-027 Reset SHALL drive wr_data, err_cnt and first_err_addr to 0.
REQ-028 Reset SHALL drive wr_addr and rd_addr to BASE_ADDR.
REQ-029 Reset SHALL set the beat and burst counters to 0.
REQ-030 Asserting rst_n low mid-burst SHALL drop wr_req and rd_req immediately.

Structure
REQ-031 The FSM state encoding, the pattern enum (PAT_INC, PAT_LFSR) and the LFSR taps table per DW SHALL live in a shared package sdram_tg_pkg.
REQ-032 Pattern generation SHALL be the sub-module sdram_tg_pattern, with ports load, seed, step and word; two instances SHALL be used, one for write and one for read-expect.

Verification
REQ-033 Single pass, defaults, with the controller plus memory model: start after init_end -> 4 write bursts at 0, 10, 20, 30 carrying data 0..39, then 4 read bursts; done pulses once, pass=1, err_cnt=0.
REQ-034 Fault injection: read beat 13 forced to 16'hDEAD -> err_cnt=1, first_err_addr=13, pass=0.
REQ-035 PATTERN=1, DW=16: first write words 16'hFFFF then the next LFSR value; read-back matches and pass=1.
REQ-036 Stall: wr_ack held low for 20 cycles mid-burst -> wr_req stays 1 and wr_data holds; the burst completes with exactly 10 beats.
REQ-037 init_end dropped during RD -> rd_req is low the next cycle, FSM returns to IDLE, busy=0, no done pulse; a subsequent start runs a clean pass.
REQ-038 LOOP=1: second pass writes data 1..40; done pulses twice across the two passes, and err_cnt clears at the start of each pass.

Source files
------------

// File: rtl/sdram_tg_pkg.sv
// Shared types for the SDRAM traffic generator: FSM states, data patterns
// and the Galois LFSR taps table.
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_NEXT = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_NEXT = 3'd4,
    ST_FIN     = 3'd5
  } tg_state_e;

  typedef enum logic {
    PAT_INC  = 1'b0,
    PAT_LFSR = 1'b1
  } tg_pattern_e;

  // Right-shifting Galois taps; bit k set means feedback into bit k.
  // Unlisted widths fall back to a plain rotation so the state never sticks at zero.
  function automatic logic [63:0] lfsr_taps(input int dw);
    logic [63:0] taps;
    case (dw)
      32'd4:   taps = 64'h0000_0000_0000_000C;
      32'd8:   taps = 64'h0000_0000_0000_00B8;
      32'd16:  taps = 64'h0000_0000_0000_B400;
      32'd24:  taps = 64'h0000_0000_00E1_0000;
      32'd32:  taps = 64'h0000_0000_8020_0003;
      32'd64:  taps = 64'hD800_0000_0000_0000;
      default: taps = 64'h0000_0000_0000_0001 << (dw - 32'd1);
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/sdram_tg_pattern.sv
// Data pattern generator: incrementing counter or Galois LFSR, loaded with a
// seed and advanced one word per step.
module sdram_tg_pattern
  import sdram_tg_pkg::*;
#(
  parameter int          DW   = 16,
  parameter tg_pattern_e MODE = PAT_INC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          step,
  output logic [DW-1:0] word
);

  localparam logic [63:0]   TAPS_ALL = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];

  logic [DW-1:0] word_r;
  logic [DW-1:0] next_s;

  // Next pattern word from the current one.
  always_comb begin
    next_s = word_r;
    if (MODE == PAT_LFSR) begin
      if (word_r[0]) begin
        next_s = (word_r >> 1) ^ TAPS;
      end else begin
        next_s = word_r >> 1;
      end
    end else begin
      next_s = word_r + DW'(1'b1);
    end
  end

  // Pattern state: load has priority over step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r <= {DW{1'b0}};
    end else if (load) begin
      word_r <= seed;
    end else if (step) begin
      word_r <= next_s;
    end
  end

  assign word = word_r;

endmodule

// File: rtl/sdram_traffic_gen.sv
// SDRAM traffic generator: writes NUM_BURSTS bursts of a pattern, reads them
// back, compares each beat and reports error count and first failing address.
module sdram_traffic_gen
  import sdram_tg_pkg::*;
#(
  parameter int DW         = 16,
  parameter int AW         = 24,
  parameter int BLW        = 10,
  parameter int BST_LEN    = 10,
  parameter int NUM_BURSTS = 4,
  parameter int BASE_ADDR  = 0,
  parameter int PATTERN    = 0,
  parameter int LOOP       = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           init_end,
  output logic           wr_req,
  output logic [AW-1:0]  wr_addr,
  output logic [DW-1:0]  wr_data,
  output logic [BLW-1:0] wr_bst_len,
  input  logic           wr_ack,
  output logic           rd_req,
  output logic [AW-1:0]  rd_addr,
  output logic [BLW-1:0] rd_bst_len,
  input  logic           rd_ack,
  input  logic [DW-1:0]  rd_data,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [15:0]    err_cnt,
  output logic [AW-1:0]  first_err_addr
);

  localparam tg_pattern_e   PAT_MODE   = (PATTERN == 1) ? PAT_LFSR : PAT_INC;
  localparam logic [15:0]   LAST_BEAT  = 16'(BST_LEN - 1);
  localparam logic [15:0]   LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [AW-1:0] ADDR_BASE  = AW'(BASE_ADDR);
  localparam logic [AW-1:0] ADDR_STEP  = AW'(BST_LEN);
  localparam logic [DW-1:0] SEED_INIT  = (PAT_MODE == PAT_LFSR) ? {DW{1'b1}} : {DW{1'b0}};

  tg_state_e     state_r, state_nxt_s;
  logic [15:0]   beat_cnt_r, burst_cnt_r;
  logic [DW-1:0] seed_r, seed_nxt_s, wr_word_s, exp_word_s;
  logic [AW-1:0] addr_r, first_err_addr_r;
  logic [15:0]   err_cnt_r;
  logic          wr_req_r, rd_req_r, busy_r, done_r, pass_r;
  logic          abort_s, wr_beat_s, rd_beat_s, last_beat_s;
  logic          pass_start_s, rd_load_s, mismatch_s, burst_end_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; losing init_end aborts any pass back to idle.
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = (state_r != ST_IDLE) && !init_end;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = (start && init_end) ? ST_WR : ST_IDLE;
        ST_WR:      state_nxt_s = (wr_ack && beat_cnt_r == LAST_BEAT) ? ST_WR_NEXT : ST_WR;
        ST_WR_NEXT: state_nxt_s = (burst_cnt_r == LAST_BURST) ? ST_RD : ST_WR;
        ST_RD:      state_nxt_s = (rd_ack && beat_cnt_r == LAST_BEAT) ? ST_RD_NEXT : ST_RD;
        ST_RD_NEXT: state_nxt_s = (burst_cnt_r == LAST_BURST) ? ST_FIN : ST_RD;
        ST_FIN:     state_nxt_s = (LOOP == 1) ? ST_WR : ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Control strobes derived from the current state.
  always_comb begin
    wr_beat_s    = (state_r == ST_WR) && wr_ack;
    rd_beat_s    = (state_r == ST_RD) && rd_ack;
    last_beat_s  = (beat_cnt_r == LAST_BEAT);
    burst_end_s  = (state_r == ST_WR_NEXT) || (state_r == ST_RD_NEXT);
    pass_start_s = (state_nxt_s == ST_WR) && ((state_r == ST_IDLE) || (state_r == ST_FIN));
    rd_load_s    = (state_r == ST_WR_NEXT) && (state_nxt_s == ST_RD);
    mismatch_s   = rd_beat_s && (rd_data != exp_word_s);
    if (state_r != ST_FIN) begin
      seed_nxt_s = SEED_INIT;
    end else if (PAT_MODE == PAT_LFSR) begin
      seed_nxt_s = wr_word_s;
    end else begin
      seed_nxt_s = seed_r + DW'(1'b1);
    end
  end

  // Registered outputs, counters and result tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_r         <= 1'b0;
      rd_req_r         <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      seed_r           <= {DW{1'b0}};
      beat_cnt_r       <= 16'd0;
      burst_cnt_r      <= 16'd0;
      addr_r           <= ADDR_BASE;
      err_cnt_r        <= 16'd0;
      first_err_addr_r <= {AW{1'b0}};
    end else begin
      wr_req_r <= (state_nxt_s == ST_WR);
      rd_req_r <= (state_nxt_s == ST_RD);
      busy_r   <= (state_nxt_s != ST_IDLE);
      done_r   <= (state_nxt_s == ST_FIN);
      if (pass_start_s) begin
        seed_r           <= seed_nxt_s;
        beat_cnt_r       <= 16'd0;
        burst_cnt_r      <= 16'd0;
        addr_r           <= ADDR_BASE;
        err_cnt_r        <= 16'd0;
        pass_r           <= 1'b0;
        first_err_addr_r <= {AW{1'b0}};
      end else begin
        if (wr_beat_s || rd_beat_s) begin
          beat_cnt_r <= last_beat_s ? 16'd0 : beat_cnt_r + 16'd1;
        end
        // The final burst of each phase rewinds to the base for the next phase.
        if (burst_end_s) begin
          if (burst_cnt_r == LAST_BURST) begin
            burst_cnt_r <= 16'd0;
            addr_r      <= ADDR_BASE;
          end else begin
            burst_cnt_r <= burst_cnt_r + 16'd1;
            addr_r      <= addr_r + ADDR_STEP;
          end
        end
        if (mismatch_s) begin
          if (err_cnt_r != 16'hFFFF) begin
            err_cnt_r <= err_cnt_r + 16'd1;
          end
          if (err_cnt_r == 16'd0) begin
            first_err_addr_r <= addr_r + AW'(beat_cnt_r);
          end
        end
        if (state_nxt_s == ST_FIN) begin
          pass_r <= (err_cnt_r == 16'd0);
        end
      end
    end
  end

  sdram_tg_pattern #(.DW(DW), .MODE(PAT_MODE)) u_wr_pat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pass_start_s),
    .seed  (seed_nxt_s),
    .step  (wr_beat_s),
    .word  (wr_word_s)
  );

  sdram_tg_pattern #(.DW(DW), .MODE(PAT_MODE)) u_rd_pat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (rd_load_s),
    .seed  (seed_r),
    .step  (rd_beat_s),
    .word  (exp_word_s)
  );

  assign wr_req         = wr_req_r;
  assign rd_req         = rd_req_r;
  assign wr_addr        = addr_r;
  assign rd_addr        = addr_r;
  assign wr_data        = wr_word_s;
  assign wr_bst_len     = BLW'(BST_LEN);
  assign rd_bst_len     = BLW'(BST_LEN);
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_cnt        = err_cnt_r;
  assign first_err_addr = first_err_addr_r;

endmodule
